// File: rtl/apcpu_pkg.sv
// Shared types and widths for the AP instruction fetch/issue path.
package apcpu_pkg;
  localparam int AP_CTX_MAX = 8;
  localparam int AP_SEL_W   = 3;
  localparam int INSTR_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo N.
module rr_arbiter
  import apcpu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [AP_SEL_W-1:0]   last,
  output logic [AP_SEL_W-1:0]   gnt_idx,
  output logic                  gnt_any
);
  logic [AP_CTX_MAX-1:0] reqExt;
  logic [AP_SEL_W-1:0]   cand;

  assign reqExt = AP_CTX_MAX'(req);

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = AP_SEL_W'((int'(last) + k) % N);
      if (!gnt_any && reqExt[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end
endmodule

// File: rtl/ap_issue_scheduler.sv
// Multi-context fetch/issue scheduler: round-robin context pick, imem fetch, Decoder issue.
// Handshakes: imem transfer happens on imem_req & imem_ack; Decoder transfer on issue_valid & dec_ready.
module ap_issue_scheduler
  import apcpu_pkg::*;
#(
  parameter int              NCTX     = 4,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCTX-1:0]     ctx_en,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  InstructionBus,
  output logic [AP_SEL_W-1:0] APSelBus,
  output logic                issue_valid,
  input  logic                dec_ready,
  input  logic                br_valid,
  input  logic [AP_SEL_W-1:0] br_ctx,
  input  logic [PC_W-1:0]     br_target,
  output logic                busy
);
  state_t                state;
  logic [AP_SEL_W-1:0]   rrPtr;
  logic [AP_SEL_W-1:0]   curCtx;
  logic [AP_SEL_W-1:0]   gntIdx;
  logic                  gntAny;
  logic                  flush;
  logic [PC_W-1:0]       pcReg [AP_CTX_MAX];
  logic [AP_CTX_MAX-1:0] ctxEnExt;
  logic                  brHit;
  logic                  handshake;
  logic                  wordValid;
  logic [PC_W-1:0]       nextAddr;

  assign ctxEnExt  = AP_CTX_MAX'(ctx_en);
  assign brHit     = br_valid && (br_ctx == curCtx);
  assign handshake = issue_valid && dec_ready;
  assign wordValid = !flush && !brHit && ctxEnExt[curCtx];
  // A redirect landing in the grant cycle is forwarded so the fetch never uses the stale PC.
  assign nextAddr  = (br_valid && (br_ctx == gntIdx)) ? br_target : pcReg[gntIdx];

  rr_arbiter #(.N(NCTX)) uArb (
    .req     (ctx_en),
    .last    (rrPtr),
    .gnt_idx (gntIdx),
    .gnt_any (gntAny)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rrPtr          <= AP_SEL_W'(NCTX - 1);
      curCtx         <= '0;
      flush          <= 1'b0;
      imem_req       <= 1'b0;
      imem_addr      <= '0;
      InstructionBus <= '0;
      APSelBus       <= '0;
      issue_valid    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gntAny) begin
            curCtx    <= gntIdx;
            rrPtr     <= gntIdx;
            imem_addr <= nextAddr;
            imem_req  <= 1'b1;
            flush     <= 1'b0;
            state     <= FETCH;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (brHit) flush <= 1'b1;
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (wordValid) begin
              InstructionBus <= imem_rdata;
              APSelBus       <= curCtx;
              issue_valid    <= 1'b1;
              state          <= ISSUE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          // A redirect of the issuing context withdraws the word unless it is taken this cycle.
          if (handshake || brHit) begin
            issue_valid <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          issue_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AP_CTX_MAX; i++) pcReg[i] <= RESET_PC;
    end else begin
      for (int i = 0; i < NCTX; i++) begin
        if (br_valid && (br_ctx == AP_SEL_W'(i)))
          pcReg[i] <= br_target;
        else if ((state == ISSUE) && handshake && (curCtx == AP_SEL_W'(i)))
          pcReg[i] <= pcReg[i] + PC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ap_issue_scheduler.sv
// Directed bench for ap_issue_scheduler with a small imem responder and inline checks.
module tb_ap_issue_scheduler;
  logic        clk;
  logic        rst;
  logic [3:0]  ctx_en;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstructionBus;
  logic [2:0]  APSelBus;
  logic        issue_valid;
  logic        dec_ready;
  logic        br_valid;
  logic [2:0]  br_ctx;
  logic [15:0] br_target;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int waitCnt = 0;
  int ackWait = 0;
  logic ackHold = 1'b0;
  logic [2:0] exp_q[$];

  ap_issue_scheduler #(.NCTX(4), .PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .ctx_en         (ctx_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .InstructionBus (InstructionBus),
    .APSelBus       (APSelBus),
    .issue_valid    (issue_valid),
    .dec_ready      (dec_ready),
    .br_valid       (br_valid),
    .br_ctx         (br_ctx),
    .br_target      (br_target),
    .busy           (busy)
  );

  // clock and imem responder
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign imem_ack = imem_req && !ackHold && (waitCnt >= ackWait);

  always @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= 0;
    else if (imem_req && !imem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ctx_en = '0; dec_ready = 1'b0; br_valid = 1'b0;
    br_ctx = '0; br_target = '0; ackWait = 0; ackHold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_branch(input logic [2:0] c, input logic [15:0] t);
    br_valid = 1'b1; br_ctx = c; br_target = t;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic wait_fetch(output logic [15:0] addr);
    bit ok = 0;
    addr = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (imem_req && imem_ack) begin ok = 1; addr = imem_addr; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL fetch_timeout got=none exp=fetch"); end
  endtask

  task automatic wait_issue(output logic [2:0] sel, output logic [31:0] ins, output int at);
    bit ok = 0;
    sel = '0; ins = '0; at = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (issue_valid && dec_ready) begin ok = 1; sel = APSelBus; ins = InstructionBus; at = cyc; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL issue_timeout got=none exp=issue"); end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
    total++; if (InstructionBus !== 32'h0) begin bad++; $display("FAIL rst_ibus got=%0h exp=0", InstructionBus); end
    total++; if (APSelBus !== 3'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", APSelBus); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", issue_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_noen_req got=%0b exp=0", imem_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_noen_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_single_ctx();
    logic [15:0] a; logic [2:0] s; logic [31:0] ins; int at; int prevAt;
    prevAt = 0;
    do_reset();
    ctx_en = 4'b0001; imem_rdata = 32'd8706; dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_fetch(a);
      total++; if (a !== 16'(k)) begin bad++; $display("FAIL single_addr got=%0h exp=%0h", a, k); end
      wait_issue(s, ins, at);
      total++; if (ins !== 32'd8706) begin bad++; $display("FAIL single_ibus got=%0d exp=8706", ins); end
      total++; if (s !== 3'd0) begin bad++; $display("FAIL single_sel got=%0d exp=0", s); end
      if (k > 0) begin
        total++; if (at - prevAt !== 3) begin bad++; $display("FAIL single_period got=%0d exp=3", at - prevAt); end
      end
      prevAt = at;
      tick();
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b exp=0", issue_valid); end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] a; logic [2:0] s; logic [2:0] e; logic [31:0] ins; int at;
    do_reset();
    ctx_en = 4'b1011; imem_rdata = 32'h0000_00A0; dec_ready = 1'b1;
    exp_q = {3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
    for (int k = 0; k < 6; k++) begin
      wait_fetch(a);
      total++; if (a !== ((k < 3) ? 16'd0 : 16'd1)) begin bad++; $display("FAIL rr_addr got=%0h exp=%0h", a, (k < 3) ? 0 : 1); end
      wait_issue(s, ins, at);
      e = exp_q.pop_front();
      total++; if (s !== e) begin bad++; $display("FAIL rr_order got=%0d exp=%0d", s, e); end
    end
    ctx_en = 4'b0100;
    wait_fetch(a);
    total++; if (a !== 16'd0) begin bad++; $display("FAIL rr_pc2 got=%0h exp=0", a); end
  endtask

  task automatic test_stall();
    logic [15:0] a;
    do_reset();
    ctx_en = 4'b1000; imem_rdata = 32'd22276; dec_ready = 1'b0;
    wait_fetch(a);
    total++; if (a !== 16'd0) begin bad++; $display("FAIL stall_addr0 got=%0h exp=0", a); end
    tick();
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0b exp=1", issue_valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (InstructionBus !== 32'd22276) begin bad++; $display("FAIL stall_ibus got=%0d exp=22276", InstructionBus); end
      total++; if (APSelBus !== 3'd3) begin bad++; $display("FAIL stall_sel got=%0d exp=3", APSelBus); end
      total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%0b exp=1", issue_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_noreq got=%0b exp=0", imem_req); end
    end
    dec_ready = 1'b1;
    wait_fetch(a);
    total++; if (a !== 16'd1) begin bad++; $display("FAIL stall_pc_inc got=%0h exp=1", a); end
  endtask

  task automatic test_flush();
    logic [15:0] a; bit seen; bit sawIssue;
    seen = 0; sawIssue = 0;
    do_reset();
    pulse_branch(3'd1, 16'd5);
    ackWait = 3; ctx_en = 4'b0010; dec_ready = 1'b1; imem_rdata = 32'hDEAD_0001;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (imem_req) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL flush_req_timeout got=none exp=req"); end
    total++; if (imem_addr !== 16'd5) begin bad++; $display("FAIL flush_addr5 got=%0h exp=5", imem_addr); end
    pulse_branch(3'd1, 16'h0040);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (issue_valid) sawIssue = 1;
      if (imem_req && imem_ack) seen = 1;
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL flush_ack_timeout got=none exp=ack"); end
    tick();
    if (issue_valid) sawIssue = 1;
    total++; if (sawIssue !== 1'b0) begin bad++; $display("FAIL flush_discard got=%0b exp=0", sawIssue); end
    wait_fetch(a);
    total++; if (a !== 16'h0040) begin bad++; $display("FAIL flush_redirect got=%0h exp=40", a); end
    ackWait = 0;
  endtask

  task automatic test_wrap_branch();
    logic [15:0] a; logic [2:0] s; logic [31:0] ins; int at;
    do_reset();
    pulse_branch(3'd0, 16'hFFFF);
    ctx_en = 4'b0001; dec_ready = 1'b1; imem_rdata = 32'h0000_0BEE;
    wait_fetch(a);
    total++; if (a !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr got=%0h exp=ffff", a); end
    wait_issue(s, ins, at);
    wait_fetch(a);
    total++; if (a !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%0h exp=0", a); end
    tick();
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL brhs_valid got=%0b exp=1", issue_valid); end
    pulse_branch(3'd0, 16'h0010);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL brhs_idle got=%0b exp=0", busy); end
    wait_fetch(a);
    total++; if (a !== 16'h0010) begin bad++; $display("FAIL brhs_pc got=%0h exp=10", a); end
    dec_ready = 1'b0;
    tick();
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL brdrop_pre got=%0b exp=1", issue_valid); end
    pulse_branch(3'd0, 16'h0020);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL brdrop_valid got=%0b exp=0", issue_valid); end
    dec_ready = 1'b1;
    wait_fetch(a);
    total++; if (a !== 16'h0020) begin bad++; $display("FAIL brdrop_pc got=%0h exp=20", a); end
    wait_issue(s, ins, at);
    pulse_branch(3'd4, 16'h0077);
    wait_fetch(a);
    total++; if (a !== 16'h0021) begin bad++; $display("FAIL br_oob got=%0h exp=21", a); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a; logic [2:0] s; logic [31:0] ins; int at; bit seen;
    seen = 0;
    do_reset();
    ctx_en = 4'b0100; dec_ready = 1'b1; imem_rdata = 32'h0000_1234;
    wait_fetch(a);
    wait_issue(s, ins, at);
    total++; if (s !== 3'd2) begin bad++; $display("FAIL mid_sel_pre got=%0d exp=2", s); end
    ackHold = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (imem_req) seen = 1;
    end
    total++; if (!seen || imem_addr !== 16'd1) begin bad++; $display("FAIL mid_req got=%0h exp=1", imem_addr); end
    #2 rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop got=%0b exp=0", imem_req); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", issue_valid); end
    total++; if (InstructionBus !== 32'h0) begin bad++; $display("FAIL mid_ibus got=%0h exp=0", InstructionBus); end
    total++; if (APSelBus !== 3'd0) begin bad++; $display("FAIL mid_sel got=%0d exp=0", APSelBus); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; ackHold = 1'b0;
    wait_fetch(a);
    total++; if (a !== 16'h0000) begin bad++; $display("FAIL mid_restart got=%0h exp=0", a); end
  endtask

  initial begin
    rst = 1'b1; ctx_en = '0; dec_ready = 1'b0; br_valid = 1'b0;
    br_ctx = '0; br_target = '0; imem_rdata = '0;
    #1;
    test_reset();
    test_single_ctx();
    test_round_robin();
    test_stall();
    test_flush();
    test_wrap_branch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
